// File: rtl/arm_data_packer.sv
// Collects WORDS input words of WORD_W bits into one wide operand, word 0 least
// significant, and holds it until the consumer takes it. Ends early on in_last.
module arm_data_packer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 32
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [WORD_W-1:0]                  in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  input  logic                               flush,
  output logic [WORD_W*WORDS-1:0]            out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(WORDS):0]             word_count
);

  localparam int unsigned OUT_W = WORD_W * WORDS;
  localparam int unsigned CW    = $clog2(WORDS) + 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q;
  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic [CW-1:0]    count_q;

  assign in_ready   = (state_q == FILL) && !flush;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign word_count = count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FILL;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (flush) begin
      state_q <= FILL;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          // count_q < WORDS here: reaching the last slot always moves to HOLD
          if (in_valid) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
              if (count_q == CW'(i)) data_q[i*WORD_W +: WORD_W] <= in_data;
            end
            count_q <= count_q + CW'(1);
            if (in_last || (count_q == CW'(WORDS - 1))) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= FILL;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= FILL;
          data_q  <= '0;
          valid_q <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_data_packer.sv
// Directed bench for arm_data_packer: full/short packets, backpressure, flush,
// reset during HOLD and back-to-back packets with the consumer always ready.
module tb_arm_data_packer;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = 32;
  localparam int unsigned OUT_W  = WORD_W * WORDS;

  logic                 clk;
  logic                 resetn;
  logic [WORD_W-1:0]    in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic                 flush;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [5:0]           word_count;

  int checks = 0;
  int errors = 0;

  arm_data_packer #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    int unsigned w;
    checks++;
    assert (obs === exp) else begin
      errors++;
      w = 0;
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (obs[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) begin
          w = i;
          break;
        end
      end
      $error("FAIL %s: word %0d observed %h required %h", tag, w,
             obs[w*WORD_W +: WORD_W], exp[w*WORD_W +: WORD_W]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [OUT_W-1:0] exp_full;
  logic [OUT_W-1:0] exp_v;
  logic [WORD_W-1:0] nv;
  logic rdy, prev_v;
  int pulses, vcyc, lowcyc;

  initial begin
    resetn = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    for (int unsigned i = 0; i < WORDS; i++) exp_full[i*WORD_W +: WORD_W] = WORD_W'(i + 1);

    #2;
    chk("rst_out_valid", OUT_W'(out_valid), '0);
    chk("rst_word_count", OUT_W'(word_count), '0);
    chk("rst_out_data", out_data, '0);
    @(negedge clk) resetn = 1'b1;
    step();
    chk("post_rst_in_ready", OUT_W'(in_ready), OUT_W'(1));

    // Full packet, consumer not ready
    for (int i = 1; i <= 32; i++) begin
      in_valid = 1'b1; in_data = WORD_W'(i); in_last = 1'b0;
      step();
      if (i == 31) chk("full_not_yet_valid", OUT_W'(out_valid), '0);
    end
    in_valid = 1'b0;
    chk("full_out_valid", OUT_W'(out_valid), OUT_W'(1));
    chk("full_word_count", OUT_W'(word_count), OUT_W'(32));
    chk("full_low_word", OUT_W'(out_data[31:0]), OUT_W'(32'h1));
    chk("full_high_word", OUT_W'(out_data[1023:992]), OUT_W'(32'h20));
    chk("full_in_ready", OUT_W'(in_ready), '0);

    // Backpressure for 10 cycles, with in_valid attempted
    in_valid = 1'b1; in_data = 32'hBAD0BAD0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", OUT_W'(out_valid), OUT_W'(1));
      chk("bp_out_data", out_data, exp_full);
      chk("bp_in_ready", OUT_W'(in_ready), '0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_out_valid", OUT_W'(out_valid), '0);
    chk("release_word_count", OUT_W'(word_count), '0);
    chk("release_in_ready", OUT_W'(in_ready), OUT_W'(1));
    chk("release_out_data", out_data, '0);

    // in_last without in_valid, out_ready while idle: both ignored
    in_last = 1'b1; out_ready = 1'b1;
    step();
    in_last = 1'b0; out_ready = 1'b0;
    chk("idle_last_count", OUT_W'(word_count), '0);
    chk("idle_last_valid", OUT_W'(out_valid), '0);

    // Short packet A, B, C
    in_valid = 1'b1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    in_data = 32'hC; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    exp_v = '0;
    exp_v[95:0] = {32'hC, 32'hB, 32'hA};
    chk("short_out_valid", OUT_W'(out_valid), OUT_W'(1));
    chk("short_out_data", out_data, exp_v);
    chk("short_word_count", OUT_W'(word_count), OUT_W'(3));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Flush after 5 words; flush wins over a simultaneous in_valid
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = WORD_W'(32'h100 + i); step();
    end
    chk("pre_flush_count", OUT_W'(word_count), OUT_W'(5));
    in_data = 32'hDEAD; flush = 1'b1;
    #1;
    chk("flush_in_ready", OUT_W'(in_ready), '0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_word_count", OUT_W'(word_count), '0);
    chk("flush_out_data", out_data, '0);
    chk("flush_out_valid", OUT_W'(out_valid), '0);
    in_valid = 1'b1; in_data = 32'h11; step();
    in_data = 32'h22; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    exp_v = '0;
    exp_v[63:0] = 64'h00000022_00000011;
    chk("after_flush_out_data", out_data, exp_v);
    chk("after_flush_count", OUT_W'(word_count), OUT_W'(2));
    chk("after_flush_valid", OUT_W'(out_valid), OUT_W'(1));

    // Flush in HOLD beats a simultaneous out_ready; then a 1-word packet
    flush = 1'b1; out_ready = 1'b1; step();
    flush = 1'b0; out_ready = 1'b0;
    chk("hold_flush_valid", OUT_W'(out_valid), '0);
    chk("hold_flush_data", out_data, '0);
    in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("one_word_valid", OUT_W'(out_valid), OUT_W'(1));

    // Asynchronous reset while holding
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", OUT_W'(out_valid), '0);
    chk("async_rst_count", OUT_W'(word_count), '0);
    chk("async_rst_data", out_data, '0);
    @(negedge clk) resetn = 1'b1;
    step();
    chk("rerst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    chk("rerst_out_valid", OUT_W'(out_valid), '0);

    // Back-to-back full packets with the consumer always ready
    out_ready = 1'b1; in_valid = 1'b1;
    nv = 32'd1; pulses = 0; vcyc = 0; lowcyc = 0; prev_v = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      in_data = nv;
      rdy = in_ready;
      step();
      if (rdy) nv = nv + 32'd1;
      if (out_valid) begin
        vcyc++;
        if (!prev_v) pulses++;
        chk("b2b_low_word", OUT_W'(out_data[31:0]), OUT_W'(pulses == 1 ? 32'd1 : 32'd33));
        chk("b2b_high_word", OUT_W'(out_data[1023:992]), OUT_W'(pulses == 1 ? 32'd32 : 32'd64));
      end
      chk("b2b_ready_vs_valid", OUT_W'(in_ready), OUT_W'(!out_valid));
      if (!in_ready) lowcyc++;
      prev_v = out_valid;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_pulses", OUT_W'(pulses), OUT_W'(2));
    chk("b2b_valid_cycles", OUT_W'(vcyc), OUT_W'(2));
    chk("b2b_ready_low_cycles", OUT_W'(lowcyc), OUT_W'(2));
    chk("b2b_end_count", OUT_W'(word_count), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
